// File: rtl/mema_load_ctrl.sv
// Load/run sequencer for the skewed A-operand memory of the systolic MAC array.
// Accepts DIM rows over a valid/ready stream, writes them row by row, then drives
// the memory shift enable for RUN_CYCLES un-stalled cycles and pulses done.
module mema_load_ctrl #(
    parameter int unsigned BITS_AB    = 8,
    parameter int unsigned DIM        = 8,
    parameter int unsigned RUN_CYCLES = 3 * DIM - 2,
    localparam int unsigned AW        = (DIM > 1) ? $clog2(DIM) : 1,
    localparam int unsigned RW        = $clog2(RUN_CYCLES + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic                              clear_i,
    input  logic                              stall_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic signed [DIM-1:0][BITS_AB-1:0] in_data_i,
    output logic                              mem_en_o,
    output logic                              mem_wren_o,
    output logic [AW-1:0]                     mem_arow_o,
    output logic signed [DIM-1:0][BITS_AB-1:0] mem_ain_o,
    output logic [RW-1:0]                     run_idx_o,
    output logic                              busy_o,
    output logic                              done_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] row_q, row_d;
    logic [RW-1:0] run_idx_q, run_idx_d;
    logic          done_q, done_d;

    // State, counters and done pulse register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            row_q     <= '0;
            run_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            run_idx_q <= run_idx_d;
            done_q    <= done_d;
        end
    end

    // Next-state, counter update and memory strobes.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        run_idx_d  = run_idx_q;
        in_ready_o = 1'b0;
        mem_en_o   = 1'b0;
        mem_wren_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StLoad;
                    row_d     = '0;
                    run_idx_d = '0;
                end
            end
            StLoad: begin
                in_ready_o = 1'b1;
                mem_wren_o = in_valid_i;
                if (in_valid_i) begin
                    if (row_q == AW'(DIM - 1)) begin
                        state_d   = StRun;
                        row_d     = '0;
                        run_idx_d = '0;
                    end else begin
                        row_d = row_q + AW'(1);
                    end
                end
            end
            StRun: begin
                mem_en_o = !stall_i;
                if (!stall_i) begin
                    run_idx_d = run_idx_q + RW'(1);
                    if (run_idx_q == RW'(RUN_CYCLES - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort wins over everything; suppress the write so no row is corrupted.
        if (clear_i) begin
            state_d    = StIdle;
            row_d      = '0;
            run_idx_d  = '0;
            mem_wren_o = 1'b0;
        end

        done_d = (state_d == StDone);
    end

    assign mem_arow_o = row_q;
    assign mem_ain_o  = in_data_i;
    assign run_idx_o  = run_idx_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;

endmodule

// File: doc/mema_load_ctrl.md
Name: mema_load_ctrl

Overview:
Sequencer for the skewed A-operand memory that feeds the systolic MAC array. It accepts DIM rows of A over a valid/ready stream and writes each row into the memory with the correct row select. It then drives the memory shift-enable for exactly the number of cycles needed to drain every skew FIFO into the array, and signals completion. One instance sits between the host/MMIO load path and the A memory.

Parameters:
BITS_AB, 8, element width of A in bits
DIM, 8, array dimension: rows per tile and elements per row
RUN_CYCLES, 3*DIM-2, enabled shift cycles in RUN (22 at DIM=8)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a tile; sampled only in IDLE
clear  in  1  synchronous abort to IDLE; has priority over all other inputs
stall  in  1  freezes the RUN phase (no shift, no count)
in_valid  in  1  row beat valid
in_ready  out  1  controller accepts row beat
in_data  in  DIM x BITS_AB signed  row of A; element [DIM-1] is column 0
mem_en  out  1  memory shift enable
mem_wren  out  1  memory row write enable
mem_arow  out  clog2(DIM)  memory row select
mem_ain  out  DIM x BITS_AB signed  memory row data
run_idx  out  clog2(RUN_CYCLES+1)  count of completed shift cycles in the current RUN
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at tile completion

Behaviour:
- States: IDLE, LOAD, RUN, DONE. State, counters and done are registered. All registers reset asynchronously on rst_n low.
- Reset values: state=IDLE, row counter=0, run_idx=0, done=0. Derived outputs at reset: in_ready=0, mem_en=0, mem_wren=0, mem_arow=0, busy=0.
- IDLE: in_ready=0, mem_en=0. start=1 -> LOAD with row counter=0. Otherwise stay.
- LOAD: in_ready=1, mem_en=0.
  - mem_wren = in_valid & in_ready, combinational.
  - mem_arow = row counter. mem_ain = in_data, combinational passthrough.
  - On each accepted beat the row counter increments.
  - Beat accepted with row counter=DIM-1 -> RUN with run_idx=0 and row counter cleared to 0.
  - in_valid=0: no write. Row counter holds, with no timeout.
- RUN: in_ready=0, mem_wren=0, mem_en = !stall.
  - run_idx increments on each cycle with stall=0.
  - The cycle in which run_idx==RUN_CYCLES-1 and stall=0 -> DONE. Exactly RUN_CYCLES cycles have mem_en=1 in RUN.
  - stall=1: mem_en=0 and run_idx holds. Stall may be asserted any number of cycles.
- DONE: mem_en=0, done=1 for exactly this one cycle. Unconditional transition to IDLE. run_idx holds its final value until the next LOAD entry.
- start while busy: ignored, no queuing.
- clear=1 in any state: next state IDLE, row counter=0, run_idx=0, done=0. mem_wren is forced to 0 in the clear cycle, so no write occurs.
- Reset mid-LOAD or mid-RUN: immediate return to reset values. Partially loaded memory contents are don't-care; the next tile fully rewrites every row.
- mem_arow is always < DIM. The row counter wraps to 0 only via the LOAD->RUN transition.
- mem_en and mem_wren are never both 1 in the same cycle.
- Latency: start to first in_ready = 1 cycle. Last row accepted to first mem_en = 1 cycle. Minimum tile = 1 + DIM + RUN_CYCLES + 1 cycles (32 at DIM=8).

Test Plan:
- DIM=8, start pulse, in_valid held 1 with rows 0..7 -> mem_wren high 8 consecutive cycles, mem_arow 0..7 with in_data passed through. Then mem_en high 22 cycles, done pulses once in cycle 32 after start, busy falls the next cycle.
- Same load with in_valid low on alternate cycles -> only valid beats write, mem_arow advances only on accepts, RUN still begins 1 cycle after the 8th accept.
- stall high for 5 cycles when run_idx=10 -> mem_en low for those 5 cycles, run_idx holds at 10, total mem_en-high cycles still 22, done delayed by 5.
- clear asserted after 3 rows loaded -> no write that cycle, next cycle IDLE with busy=0. A new start reloads from mem_arow=0.
- rst_n low for 2 cycles mid-RUN (run_idx=7) -> all outputs at reset values asynchronously. After release, start is required to begin again.
- start pulses during LOAD and RUN -> ignored. Exactly one done per tile. mem_en&mem_wren never 1 (assertion for the whole run).
